// File: rtl/if_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register.
// Update priority is rst > redirect_valid > flush > stall > advance.
// The instruction memory answers combinationally, so a fetch takes one cycle.
// Optional macro IF_PERF_EN adds fetch_cnt / bubble_cnt performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_inst,
  output logic        ifid_valid
`ifdef IF_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam logic [31:0] NopInst  = 32'h0000_0013;
  localparam logic [31:0] AlignMsk = 32'hFFFF_FFFC;
  // Reset PC is aligned too, so the low two PC bits are always zero.
  localparam logic [31:0] ResetPcA = RESET_PC & AlignMsk;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        load_fetch;   // this edge loads a real instruction
  logic        load_bubble;  // this edge loads a bubble

  // Next-state selection for PC and IF/ID (reset handled in the flop block).
  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    load_fetch   = 1'b0;
    load_bubble  = 1'b0;
    if (redirect_valid) begin
      pc_d         = redirect_pc & AlignMsk;
      ifid_pc_d    = 32'h0;
      ifid_inst_d  = NopInst;
      ifid_valid_d = 1'b0;
      load_bubble  = 1'b1;
    end else if (flush) begin
      if (!stall) pc_d = pc_q + 32'd4;
      ifid_pc_d    = 32'h0;
      ifid_inst_d  = NopInst;
      ifid_valid_d = 1'b0;
      load_bubble  = 1'b1;
    end else if (!stall) begin
      pc_d         = pc_q + 32'd4;
      ifid_pc_d    = pc_q;
      ifid_inst_d  = imem_inst;
      ifid_valid_d = 1'b1;
      load_fetch   = 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= ResetPcA;
      ifid_pc_q    <= 32'h0;
      ifid_inst_q  <= NopInst;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_pc4   = ifid_pc_q + 32'd4;
  assign ifid_inst  = ifid_inst_q;
  assign ifid_valid = ifid_valid_q;

`ifdef IF_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (load_fetch)  fetch_cnt_d  = fetch_cnt_q + 32'd1;
    if (load_bubble) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = load_fetch ^ load_bubble;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, reset-PC wrap
// sequence, optional perf-counter sequence and randomized run against a model.
module tb_if_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_inst, ifid_pc, ifid_pc4, ifid_inst;
  logic        ifid_valid;
`ifdef IF_PERF_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  // Second instance for the reset-PC wrap check.
  logic        rst1;
  logic [31:0] imem_addr1, imem_inst1, ifid_pc1, ifid_pc41, ifid_inst1;
  logic        ifid_valid1;
`ifdef IF_PERF_EN
  logic [31:0] fetch_cnt1, bubble_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  // Instruction memory contents: a small program plus a hashed background.
  function automatic logic [31:0] inst_at(input logic [31:0] a);
    case (a)
      32'h0000_0000: inst_at = 32'h800000b7;
      32'h0000_0004: inst_at = 32'hfff08093;
      32'h0000_0008: inst_at = 32'h00108113;
      32'h0000_0070: inst_at = 32'h00000463;
      default:       inst_at = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign imem_inst  = inst_at(imem_addr);
  assign imem_inst1 = inst_at(imem_addr1);

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_inst(imem_inst),
    .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_inst(ifid_inst),
    .ifid_valid(ifid_valid)
`ifdef IF_PERF_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst1), .stall(1'b0), .flush(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_addr(imem_addr1), .imem_inst(imem_inst1),
    .ifid_pc(ifid_pc1), .ifid_pc4(ifid_pc41), .ifid_inst(ifid_inst1),
    .ifid_valid(ifid_valid1)
`ifdef IF_PERF_EN
    , .fetch_cnt(fetch_cnt1), .bubble_cnt(bubble_cnt1)
`endif
  );

  // Reference model state: what the fetch stage should hold after each edge.
  logic [31:0] m_pc, m_ipc, m_inst, m_fcnt, m_bcnt;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the stage's rules, compare.
  task automatic step(input logic r, input logic s, input logic f, input logic rv,
                      input logic [31:0] rpc);
    logic [31:0] fetched;
    rst = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
    fetched = inst_at(m_pc);
    @(posedge clk);
    #1;
    if (r) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_inst = 32'h13; m_valid = 1'b0;
      m_fcnt = 0; m_bcnt = 0;
    end else if (rv) begin
      m_pc = (rpc / 4) * 4; m_ipc = 0; m_inst = 32'h13; m_valid = 1'b0;
      m_bcnt++;
    end else if (f) begin
      if (!s) m_pc = m_pc + 4;
      m_ipc = 0; m_inst = 32'h13; m_valid = 1'b0;
      m_bcnt++;
    end else if (!s) begin
      m_ipc = m_pc; m_inst = fetched; m_valid = 1'b1; m_pc = m_pc + 4;
      m_fcnt++;
    end
    chk("imem_addr", imem_addr, m_pc);
    chk("ifid_pc", ifid_pc, m_ipc);
    chk("ifid_pc4", ifid_pc4, m_ipc + 4);
    chk("ifid_inst", ifid_inst, m_inst);
    chk("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
`ifdef IF_PERF_EN
    chk("fetch_cnt", fetch_cnt, m_fcnt);
    chk("bubble_cnt", bubble_cnt, m_bcnt);
`endif
  endtask

  typedef struct {
    logic        r, s, f, rv;
    logic [31:0] rpc;
    logic [31:0] e_addr, e_pc, e_inst;
    logic        e_valid;
  } vec_t;

  vec_t vecs[14];

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    rst1 = 1'b1;
    m_pc = 0; m_ipc = 0; m_inst = 32'h13; m_valid = 0; m_fcnt = 0; m_bcnt = 0;

    //             r     s     f     rv    rpc     addr    pc      inst                 valid
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h00, 32'h00, 32'h13,             1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h04, 32'h00, 32'h800000b7,       1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h08, 32'h04, 32'hfff08093,       1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h08, 32'h04, 32'hfff08093,       1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h08, 32'h04, 32'hfff08093,       1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h08, 32'h04, 32'hfff08093,       1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0C, 32'h08, 32'h00108113,       1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h73, 32'h70, 32'h00, 32'h13,             1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h74, 32'h70, 32'h00000463,       1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 32'h20, 32'h00, 32'h13,             1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h20, 32'h00, 32'h13,             1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h24, 32'h00, 32'h13,             1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h28, 32'h24, inst_at(32'h24),    1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h00, 32'h00, 32'h13,             1'b0};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].r, vecs[i].s, vecs[i].f, vecs[i].rv, vecs[i].rpc);
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_pc", i), ifid_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_pc4", i), ifid_pc4, vecs[i].e_pc + 32'd4);
      chk($sformatf("vec%0d_inst", i), ifid_inst, vecs[i].e_inst);
      chk($sformatf("vec%0d_valid", i), {31'h0, ifid_valid}, {31'h0, vecs[i].e_valid});
    end

    // Reset PC at the top of the address space wraps to zero.
    @(posedge clk); #1;
    chk("wrap_rst_addr", imem_addr1, 32'hFFFF_FFFC);
    chk("wrap_rst_valid", {31'h0, ifid_valid1}, 32'h0);
    rst1 = 1'b0;
    @(posedge clk); #1;
    chk("wrap1_pc", ifid_pc1, 32'hFFFF_FFFC);
    chk("wrap1_pc4", ifid_pc41, 32'h0);
    chk("wrap1_addr", imem_addr1, 32'h0);
    chk("wrap1_inst", ifid_inst1, inst_at(32'hFFFF_FFFC));
    @(posedge clk); #1;
    chk("wrap2_pc", ifid_pc1, 32'h0);
    chk("wrap2_pc4", ifid_pc41, 32'h4);
    chk("wrap2_inst", ifid_inst1, 32'h800000b7);

`ifdef IF_PERF_EN
    // Ten fetches, then reset coinciding with a redirect clears everything.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("perf_fetch10", fetch_cnt, 32'd10);
    chk("perf_bubble0", bubble_cnt, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    chk("perf_rst_fetch", fetch_cnt, 32'd0);
    chk("perf_rst_bubble", bubble_cnt, 32'd0);
    chk("perf_rst_addr", imem_addr, 32'h0);
    chk("perf_rst_valid", {31'h0, ifid_valid}, 32'h0);
`endif

    // Randomized control mix, including misaligned redirect targets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
